// File: rtl/huc6280_irq_timer.sv
// HuC6280-style interrupt controller with a 7-bit down-counting timer.
// Define HUC6280_TIMER_EN to build the timer; without it only the mask and external IRQ paths exist.
module huc6280_irq_timer #(
    parameter int PRESCALE = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       sel,
    input  logic       we,
    input  logic [7:0] dIn,
    output logic [7:0] dOut,
    input  logic       irq1,
    input  logic       irq2,
    output logic       IRQ,
    output logic [1:0] vec
);

    logic       wr;
    logic       rd;
    logic [2:0] mask;
    logic       tiq;
    logic       unused_bits;

    assign wr          = sel & we;
    assign rd          = sel & ~we;
    assign unused_bits = ^dIn[7:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= 3'b000;
        end else if (wr && addr == 2'd2) begin
            mask <= dIn[2:0];
        end
    end

`ifdef HUC6280_TIMER_EN
    localparam int PS_W = $clog2(PRESCALE);

    logic [6:0]      reload;
    logic [6:0]      count;
    logic [6:0]      next_reload;
    logic            ten;
    logic [PS_W-1:0] ps;
    logic            tick;
    logic            underflow;

    assign tick      = ten && (ps == PS_W'(PRESCALE - 1));
    assign underflow = tick && (count == 7'd0);
    // A reload write landing on the underflow edge must be the value that gets loaded.
    assign next_reload = (wr && addr == 2'd0) ? dIn[6:0] : reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload <= 7'd0;
            count  <= 7'd0;
            ten    <= 1'b0;
            ps     <= '0;
            tiq    <= 1'b0;
        end else begin
            if (wr && addr == 2'd0) begin
                reload <= dIn[6:0];
            end
            if (wr && addr == 2'd1) begin
                ten <= dIn[0];
            end
            if (wr && addr == 2'd1 && dIn[0] && !ten) begin
                count <= reload;
                ps    <= '0;
            end else if (ten) begin
                ps <= tick ? '0 : ps + PS_W'(1);
                if (tick) begin
                    count <= (count == 7'd0) ? next_reload : count - 7'd1;
                end
            end
            // Underflow wins over a same-cycle acknowledge.
            if (underflow) begin
                tiq <= 1'b1;
            end else if (wr && addr == 2'd3) begin
                tiq <= 1'b0;
            end
        end
    end

    always_comb begin
        dOut = 8'h00;
        if (rd) begin
            case (addr)
                2'd0:    dOut = {1'b0, count};
                2'd1:    dOut = {7'b0, ten};
                2'd2:    dOut = {5'b0, mask};
                default: dOut = {5'b0, tiq, irq1, irq2};
            endcase
        end
    end
`else
    assign tiq = 1'b0;

    always_comb begin
        dOut = 8'h00;
        if (rd) begin
            case (addr)
                2'd2:    dOut = {5'b0, mask};
                2'd3:    dOut = {5'b0, tiq, irq1, irq2};
                default: dOut = 8'h00;
            endcase
        end
    end
`endif

    always_comb begin
        IRQ = (tiq & ~mask[2]) | (irq1 & ~mask[1]) | (irq2 & ~mask[0]);
        vec = 2'd0;
        if (tiq && !mask[2]) begin
            vec = 2'd1;
        end else if (irq1 && !mask[1]) begin
            vec = 2'd2;
        end else if (irq2 && !mask[0]) begin
            vec = 2'd3;
        end
    end

endmodule

// File: tb/tb_huc6280_irq_timer.sv
// Directed testbench for huc6280_irq_timer (PRESCALE=4); covers the timer only when HUC6280_TIMER_EN is defined.
module tb_huc6280_irq_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr;
    logic       sel;
    logic       we;
    logic [7:0] dIn;
    logic [7:0] dOut;
    logic       irq1;
    logic       irq2;
    logic       IRQ;
    logic [1:0] vec;

    int testCount = 0;
    int failCount = 0;
    logic [7:0] rdata;

    huc6280_irq_timer #(.PRESCALE(4)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .sel  (sel),
        .we   (we),
        .dIn  (dIn),
        .dOut (dOut),
        .irq1 (irq1),
        .irq2 (irq2),
        .IRQ  (IRQ),
        .vec  (vec)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One register write; the write takes effect on the next rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        sel  = 1'b1;
        we   = 1'b1;
        addr = a;
        dIn  = d;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
        dIn = 8'h00;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [7:0] d);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d   = dOut;
        sel = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [7:0] expected);
        readReg(a, rdata);
        checkOutput(tag, rdata, expected);
    endtask

    initial begin
        reset = 1'b1;
        addr  = 2'd0;
        sel   = 1'b0;
        we    = 1'b0;
        dIn   = 8'h00;
        irq1  = 1'b0;
        irq2  = 1'b0;
        cycles(2);
        reset = 1'b0;

        checkOutput("reset_irq", {7'b0, IRQ}, 8'h00);
        checkOutput("reset_vec", {6'b0, vec}, 8'h00);
        checkReg("reset_addr0", 2'd0, 8'h00);
        checkReg("reset_addr1", 2'd1, 8'h00);
        checkReg("reset_addr2", 2'd2, 8'h00);
        checkReg("reset_addr3", 2'd3, 8'h00);

`ifdef HUC6280_TIMER_EN
        applyStimulus(2'd0, 8'd2);
        applyStimulus(2'd1, 8'd1);
        checkReg("count_at_enable", 2'd0, 8'd2);
        cycles(3);
        checkReg("count_before_tick", 2'd0, 8'd2);
        cycles(1);
        checkReg("count_after_4", 2'd0, 8'd1);
        cycles(4);
        checkReg("count_after_8", 2'd0, 8'd0);
        cycles(3);
        checkOutput("irq_clk11", {7'b0, IRQ}, 8'h00);
        cycles(1);
        checkOutput("irq_clk12", {7'b0, IRQ}, 8'h01);
        checkOutput("vec_clk12", {6'b0, vec}, 8'h01);
        checkReg("count_reloaded", 2'd0, 8'd2);
        checkReg("status_tiq", 2'd3, 8'h04);

        applyStimulus(2'd3, 8'hFF);
        checkOutput("irq_after_ack", {7'b0, IRQ}, 8'h00);
        checkReg("status_after_ack", 2'd3, 8'h00);

        // Next underflow falls 12 edges after the previous one.
        cycles(10);
        applyStimulus(2'd3, 8'hFF);
        checkOutput("ack_on_underflow_irq", {7'b0, IRQ}, 8'h01);
        checkReg("ack_on_underflow_status", 2'd3, 8'h04);
        applyStimulus(2'd3, 8'h00);
        checkOutput("ack_again_irq", {7'b0, IRQ}, 8'h00);

        cycles(10);
        applyStimulus(2'd0, 8'd5);
        checkReg("reload_on_underflow", 2'd0, 8'd5);
        checkOutput("reload_on_underflow_irq", {7'b0, IRQ}, 8'h01);
        applyStimulus(2'd3, 8'h00);

        applyStimulus(2'd1, 8'd0);
        cycles(10);
        checkReg("paused_count", 2'd0, 8'd5);
        checkReg("paused_ten", 2'd1, 8'd0);
        applyStimulus(2'd0, 8'd3);
        checkReg("paused_after_reload_write", 2'd0, 8'd5);
        applyStimulus(2'd1, 8'd1);
        checkReg("reenable_reload", 2'd0, 8'd3);

        cycles(15);
        checkOutput("irq_before_u3", {7'b0, IRQ}, 8'h00);
        cycles(1);
        checkOutput("irq_u3", {7'b0, IRQ}, 8'h01);
        cycles(4);
        checkReg("midcount", 2'd0, 8'd2);
        applyStimulus(2'd2, 8'h01);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        checkOutput("midreset_irq", {7'b0, IRQ}, 8'h00);
        checkReg("midreset_addr0", 2'd0, 8'h00);
        checkReg("midreset_addr1", 2'd1, 8'h00);
        checkReg("midreset_addr2", 2'd2, 8'h00);
        checkReg("midreset_addr3", 2'd3, 8'h00);
        cycles(8);
        checkReg("post_reset_frozen", 2'd0, 8'h00);
`else
        applyStimulus(2'd1, 8'd1);
        applyStimulus(2'd0, 8'h7F);
        cycles(100);
        checkReg("notimer_addr0", 2'd0, 8'h00);
        checkReg("notimer_addr1", 2'd1, 8'h00);
        checkReg("notimer_status", 2'd3, 8'h00);
        checkOutput("notimer_irq", {7'b0, IRQ}, 8'h00);
        checkOutput("notimer_vec", {6'b0, vec}, 8'h00);
        applyStimulus(2'd2, 8'hFC);
        checkReg("notimer_mask2", 2'd2, 8'h04);
`endif

        applyStimulus(2'd2, 8'h00);
        irq1 = 1'b1;
        irq2 = 1'b1;
        #1;
        checkOutput("both_irq", {7'b0, IRQ}, 8'h01);
        checkOutput("both_vec", {6'b0, vec}, 8'h02);
        checkOutput("dout_idle", dOut, 8'h00);
        applyStimulus(2'd2, 8'h02);
        checkOutput("mask1_vec", {6'b0, vec}, 8'h03);
        checkOutput("mask1_irq", {7'b0, IRQ}, 8'h01);
        applyStimulus(2'd2, 8'h03);
        checkOutput("mask3_irq", {7'b0, IRQ}, 8'h00);
        checkOutput("mask3_vec", {6'b0, vec}, 8'h00);
        checkReg("mask3_status", 2'd3, 8'h03);
        checkReg("mask3_readback", 2'd2, 8'h03);
        irq1 = 1'b0;
        applyStimulus(2'd2, 8'h02);
        checkOutput("irq2_only_vec", {6'b0, vec}, 8'h03);
        checkReg("irq2_only_status", 2'd3, 8'h01);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/huc6280_irq_timer.md
HUC6280_IRQ_TIMER -- requirements
Module: huc6280_irq_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1024, clk cycles per timer tick (legal range 2..65536).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port addr  input  2  register offset: 0 timer reload/count, 1 timer control, 2 IRQ disable mask, 3 IRQ status/ack.
REQ-005 SHALL have port sel  input  1  access strobe for this block (decoded by the CPU bus from AB).
REQ-006 SHALL have port we  input  1  write enable (CPU WE), qualified by sel.
REQ-007 SHALL have port dIn  input  8  write data (CPU DO).
REQ-008 SHALL have port dOut  output  8  read data toward CPU DI.
REQ-009 SHALL have ports irq1, irq2  input  1 each  active-high level-sensitive external requests.
REQ-010 SHALL have port IRQ  output  1  active-high interrupt request to cpu_65c02.
REQ-011 SHALL have port vec  output  2  highest-priority unmasked pending source: 0 none, 1 timer, 2 irq1, 3 irq2.

Function
REQ-012 SHALL hold reload[6:0], count[6:0], ten (timer enable), mask[2:0] (bit0 irq2, bit1 irq1, bit2 timer; 1 = disabled), tiq (timer pending), prescaler counter ps.
REQ-013 SHALL, on sel&we: addr0 -> reload<=dIn[6:0]; addr1 -> ten<=dIn[0]; addr2 -> mask<=dIn[2:0]; addr3 -> tiq<=0 (any data).
REQ-014 SHALL drive dOut combinationally when sel&!we: addr0 {1'b0,count}; addr1 {7'b0,ten}; addr2 {5'b0,mask}; addr3 {5'b0,tiq,irq1,irq2}; dOut=0 when sel is low.
REQ-015 SHALL, on a ten 0->1 write, load count<=reload and ps<=0 in the same edge.
REQ-016 SHALL, while ten=1, increment ps each clk; at ps=PRESCALE-1, wrap ps to 0 and emit one tick.
REQ-017 SHALL on a tick: count!=0 -> count<=count-1; count=0 -> count<=reload and tiq<=1.
REQ-018 SHALL, while ten=0, freeze count and ps; tiq is retained.
REQ-019 SHALL give a same-cycle tick-underflow priority over an addr3 ack (tiq stays 1).
REQ-020 SHALL apply a reload write coinciding with an underflow before the reload (new value loaded).
REQ-021 SHALL drive IRQ = (tiq&!mask[2]) | (irq1&!mask[1]) | (irq2&!mask[0]), combinational, zero latency.
REQ-022 SHALL drive vec with priority timer > irq1 > irq2 over the unmasked terms of REQ-021.
REQ-023 SHALL NOT latch irq1/irq2; their status follows the input level.

Reset
REQ-024 SHALL, on reset high at a clk edge, set reload=0, count=0, ten=0, ps=0, tiq=0, mask=3'b000; thus IRQ=0 and vec=0 unless irq1/irq2 are high.
REQ-025 SHALL let reset override any concurrent write or tick, including mid-count.

Configuration
REQ-026 SHALL compile the timer only when macro HUC6280_TIMER_EN is defined.
REQ-027 SHALL, without HUC6280_TIMER_EN, omit reload/count/ten/ps/tiq logic: addr0/addr1 read 0, writes there ignored, tiq constant 0, vec never 1; mask[2] remains read/writable.

Verification (bench uses PRESCALE=4)
REQ-028 SHALL test: reset, write reload=2, ten=1 -> count reads 2,1,0 at 4-clk steps; tiq=1 and IRQ=1, vec=1 exactly 12 clks after enable edge; count reads 2.
REQ-029 SHALL test: with tiq=1 write addr3=8'hFF -> tiq=0, IRQ=0 next cycle; ack on underflow edge -> tiq stays 1.
REQ-030 SHALL test: irq1=1, irq2=1, mask=3'b000 -> vec=2; write mask=3'b010 -> vec=3; mask=3'b011 -> IRQ=0, status reads 8'h03.
REQ-031 SHALL test: ten=1 counting, write ten=0 for 10 clks -> count unchanged; ten=1 rewrite -> count reloads from reload.
REQ-032 SHALL test: reset asserted mid-count with tiq=1 -> all registers read 0 next cycle, IRQ=0.
REQ-033 SHALL test: build without HUC6280_TIMER_EN, write addr1=1 and run 100 clks -> addr0/addr1 read 0, IRQ=0.
